// File: rtl/poly_pkg.sv
`default_nettype none
// ============================================================================
//  Package : poly_pkg
//  Brief   : Shared mode encodings, FSM state type and multiplier latency
//            constants for the Barrett multiplier sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package poly_pkg;

    // Multiplier latencies (enable -> result), in cycles
    localparam int MM_LAT = 4;   // plain modular multiply pipeline
    localparam int CP_LAT = 1;   // compress/decompress/decompose path

    // compress field encodings
    localparam logic [1:0] COMP_NONE   = 2'b00;
    localparam logic [1:0] COMP_ON     = 2'b01;
    localparam logic [1:0] COMP_DECOMP = 2'b11;

    // duv_mode field: selects the compression bit width
    localparam logic [1:0] DUV_DU10 = 2'b00;
    localparam logic [1:0] DUV_DU11 = 2'b01;
    localparam logic [1:0] DUV_DV4  = 2'b10;
    localparam logic [1:0] DUV_DV5  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } seq_state_e;

    // Plain modmul uses the long pipeline; every other mode is single-cycle
    function automatic logic mode_is_plain(input logic [1:0] comp, input logic [1:0] dec);
        return (comp == COMP_NONE) && !dec[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/poly_mm_seq_dly.sv
`default_nettype none
// ============================================================================
//  Module  : poly_mm_seq_dly
//  Brief   : Shift register of {valid, index} pairs with one run-time
//            selectable tap and one fixed valid tap.
//  Rev     : 1.0  initial release
// ============================================================================
module poly_mm_seq_dly #(
    parameter int IDX_W   = 8,
    parameter int DEPTH   = 5,   // must be >= 2
    parameter int FIX_TAP = 1,   // 1..DEPTH, delay of fix_valid_o
    parameter int TAP_W   = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic [IDX_W-1:0] in_idx_i,
    input  logic [TAP_W-1:0] tap_sel_i,    // delay in cycles, 1..DEPTH
    output logic             tap_valid_o,
    output logic [IDX_W-1:0] tap_idx_o,
    output logic             fix_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [IDX_W-1:0] idx_q [DEPTH];

    // Stage k holds the entry issued k+1 cycles ago
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int k = 0; k < DEPTH; k++) idx_q[k] <= '0;
        end else begin
            valid_q  <= {valid_q[DEPTH-2:0], in_valid_i};
            idx_q[0] <= in_idx_i;
            for (int k = 1; k < DEPTH; k++) idx_q[k] <= idx_q[k-1];
        end
    end

    // Selectable tap; out-of-range selections read as empty
    always_comb begin
        tap_valid_o = 1'b0;
        tap_idx_o   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (int'(tap_sel_i) == k + 1) begin
                tap_valid_o = valid_q[k];
                tap_idx_o   = idx_q[k];
            end
        end
    end

    assign fix_valid_o = valid_q[FIX_TAP-1];

endmodule
`default_nettype wire

// File: rtl/poly_mm_seq.sv
`default_nettype none
// ============================================================================
//  Module  : poly_mm_seq
//  Brief   : Sequencer streaming coefficient pairs from the A/B RAMs through
//            the pipelined Barrett multiplier into the destination RAM.
//  Rev     : 1.0  initial release
// ============================================================================
module poly_mm_seq #(
    parameter int DATA_W  = 24,
    parameter int ADDR_W  = 8,
    parameter int RAM_LAT = 1,
    parameter int MM_LAT  = poly_pkg::MM_LAT,
    parameter int CP_LAT  = poly_pkg::CP_LAT
) (
    input  logic              seq_clk,
    input  logic              seq_rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [1:0]        cfg_duv,
    input  logic [1:0]        cfg_comp,
    input  logic [1:0]        cfg_dec,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_a_data,
    input  logic [DATA_W-1:0] rd_b_data,
    output logic              mm_enable,
    output logic [DATA_W-1:0] mm_a,
    output logic [DATA_W-1:0] mm_b,
    output logic [1:0]        mm_duv,
    output logic [1:0]        mm_comp,
    output logic [1:0]        mm_dec,
    input  logic              mm_valid,
    input  logic [DATA_W-1:0] mm_result,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import poly_pkg::*;

    localparam int c_DEPTH = RAM_LAT + MM_LAT;
    localparam int c_TAP_W = $clog2(c_DEPTH + 1);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [1:0]        duv_q, duv_d;
    logic [1:0]        comp_q, comp_d;
    logic [1:0]        dec_q, dec_d;
    logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]   wr_cnt_q, wr_cnt_d;   // one extra bit: counts up to len+1
    logic              err_q, err_d;

    logic               w_plain;
    logic               w_accept;
    logic               w_done;
    logic               w_issue;
    logic [c_TAP_W-1:0] w_tap_sel;
    logic               w_tap_valid;
    logic [ADDR_W-1:0]  w_tap_idx;
    logic               w_en_dly;

    assign w_plain   = mode_is_plain(comp_q, dec_q);
    assign w_issue   = (state_q == ST_ISSUE);
    assign w_done    = (state_q == ST_DRAIN) && (wr_cnt_q == ({1'b0, len_q} + (ADDR_W+1)'(1)));
    assign w_tap_sel = w_plain ? c_TAP_W'(RAM_LAT + MM_LAT) : c_TAP_W'(RAM_LAT + CP_LAT);

    // In-flight tracker: mm_enable comes off the RAM-latency tap, writes off the mode tap
    poly_mm_seq_dly #(
        .IDX_W   (ADDR_W),
        .DEPTH   (c_DEPTH),
        .FIX_TAP (RAM_LAT),
        .TAP_W   (c_TAP_W)
    ) u_dly (
        .clk_i       (seq_clk),
        .rst_i       (seq_rst),
        .in_valid_i  (w_issue),
        .in_idx_i    (rd_cnt_q),
        .tap_sel_i   (w_tap_sel),
        .tap_valid_o (w_tap_valid),
        .tap_idx_o   (w_tap_idx),
        .fix_valid_o (w_en_dly)
    );

    // State and run-context registers
    always_ff @(posedge seq_clk or posedge seq_rst) begin
        if (seq_rst) begin
            state_q  <= ST_IDLE;
            len_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            duv_q    <= '0;
            comp_q   <= '0;
            dec_q    <= '0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            duv_q    <= duv_d;
            comp_q   <= comp_d;
            dec_q    <= dec_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state: IDLE -> ISSUE -> DRAIN -> IDLE, counters and sticky error
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        src_d    = src_q;
        dst_d    = dst_q;
        duv_d    = duv_q;
        comp_d   = comp_q;
        dec_d    = dec_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        err_d    = err_q;
        w_accept = 1'b0;

        if (w_issue)     rd_cnt_d = rd_cnt_q + ADDR_W'(1);
        if (w_tap_valid) wr_cnt_d = wr_cnt_q + (ADDR_W+1)'(1);
        // Only the plain pipeline has a trustworthy valid to cross-check
        if (w_plain && (mm_valid != w_tap_valid)) err_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) w_accept = 1'b1;
            end
            ST_ISSUE: begin
                if (rd_cnt_q == len_q) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_done) begin
                    state_d  = ST_IDLE;
                    w_accept = start;   // back-to-back start on the done cycle
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (w_accept) begin
            state_d  = ST_ISSUE;
            len_d    = len;
            src_d    = src_base;
            dst_d    = dst_base;
            duv_d    = cfg_duv;
            comp_d   = cfg_comp;
            dec_d    = cfg_dec;
            rd_cnt_d = '0;
            wr_cnt_d = '0;
            err_d    = 1'b0;
        end
    end

    // Outputs are gated by their strobes so everything reads 0 outside activity
    assign rd_en     = w_issue;
    assign rd_addr   = w_issue ? (src_q + rd_cnt_q) : '0;
    assign mm_enable = w_en_dly;
    assign mm_a      = w_en_dly ? rd_a_data : '0;
    assign mm_b      = w_en_dly ? rd_b_data : '0;
    assign mm_duv    = duv_q;
    assign mm_comp   = comp_q;
    assign mm_dec    = dec_q;
    assign wr_en     = w_tap_valid;
    assign wr_addr   = w_tap_valid ? (dst_q + w_tap_idx) : '0;
    assign wr_data   = w_tap_valid ? mm_result : '0;
    assign busy      = (state_q != ST_IDLE) && !w_done;
    assign done      = w_done;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_poly_mm_seq.sv
`default_nettype none
// ============================================================================
//  Module  : tb_poly_mm_seq
//  Brief   : Self-checking bench for poly_mm_seq with behavioural RAMs and a
//            behavioural Barrett multiplier (q = 8380417).
//  Rev     : 1.0  initial release
// ============================================================================
module tb_poly_mm_seq;

    localparam int      Q    = 8380417;
    localparam int      LATP = 4;   // plain multiplier latency
    localparam int      LATC = 1;   // compress-path latency
    localparam int      RL   = 1;   // RAM read latency

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  len = '0, src_base = '0, dst_base = '0;
    logic [1:0]  cfg_duv = '0, cfg_comp = '0, cfg_dec = '0;
    logic        rd_en, mm_enable, wr_en, busy, done, err, mm_valid;
    logic [7:0]  rd_addr, wr_addr;
    logic [23:0] rd_a_data = '0, rd_b_data = '0, mm_a, mm_b, mm_result, wr_data;
    logic [1:0]  mm_duv, mm_comp, mm_dec;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    poly_mm_seq #(.DATA_W(24), .ADDR_W(8), .RAM_LAT(RL)) dut (
        .seq_clk(clk), .seq_rst(rst), .start(start), .len(len),
        .src_base(src_base), .dst_base(dst_base),
        .cfg_duv(cfg_duv), .cfg_comp(cfg_comp), .cfg_dec(cfg_dec),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_a_data(rd_a_data), .rd_b_data(rd_b_data),
        .mm_enable(mm_enable), .mm_a(mm_a), .mm_b(mm_b),
        .mm_duv(mm_duv), .mm_comp(mm_comp), .mm_dec(mm_dec),
        .mm_valid(mm_valid), .mm_result(mm_result),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .err(err)
    );

    // ---------------- RAM models (1-cycle read latency) ----------------
    logic [23:0] ram_a [0:255];
    logic [23:0] ram_b [0:255];
    logic [23:0] ram_d [0:255];

    always @(posedge clk) begin
        if (rd_en) begin
            rd_a_data <= ram_a[rd_addr];
            rd_b_data <= ram_b[rd_addr];
        end
        if (wr_en) ram_d[wr_addr] <= wr_data;
    end

    // ---------------- Multiplier model ----------------
    logic [23:0] pr [4];
    logic [3:0]  pv;
    logic [23:0] cr;
    logic        kill = 1'b0;
    logic        mdl_plain;
    logic [63:0] prod;

    assign mdl_plain = (mm_comp == 2'b00) && !mm_dec[0];
    assign prod      = {40'b0, mm_a} * {40'b0, mm_b};

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) pr[k] <= '0;
            pv <= '0;
            cr <= '0;
        end else begin
            pr[0] <= 24'(prod % 64'(Q));
            for (int k = 1; k < 4; k++) pr[k] <= pr[k-1];
            pv    <= {pv[2:0], mm_enable & mdl_plain};
            cr    <= 24'((prod + 64'd4194304) >> 23);
        end
    end

    assign mm_result = mdl_plain ? pr[3] : cr;
    assign mm_valid  = mdl_plain ? (pv[3] & ~kill) : 1'b0;

    // ---------------- Monitor (samples on falling edge) ----------------
    int cyc = 0;
    int first_rd = -1;
    int done_cnt = 0;
    int done_cyc = 0;
    bit busy_at_done = 1'b0;
    int rd_q[$], rc_q[$], wa_q[$], wd_q[$], wc_q[$], dc_q[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            rd_q.push_back(int'(rd_addr));
            rc_q.push_back(cyc);
        end
        if (wr_en) begin
            wa_q.push_back(int'(wr_addr));
            wd_q.push_back(int'(wr_data));
            wc_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
            busy_at_done = busy;
            dc_q.push_back(cyc);
        end
    end

    // ---------------- Reference model ----------------
    function automatic int ref_mul(input int a, input int b, input bit cp);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        if (cp) return int'((p + 64'd4194304) >> 23);
        return int'(p % 64'(Q));
    endfunction

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        first_rd = -1; done_cnt = 0; done_cyc = 0; busy_at_done = 1'b0;
        rd_q.delete(); rc_q.delete(); wa_q.delete(); wd_q.delete(); wc_q.delete(); dc_q.delete();
    endtask

    task automatic pulse_start(input int l, input int s, input int d,
                               input logic [1:0] duv, input logic [1:0] comp, input logic [1:0] dec);
        len = 8'(l); src_base = 8'(s); dst_base = 8'(d);
        cfg_duv = duv; cfg_comp = comp; cfg_dec = dec;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input int cnt, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt >= cnt) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // ---------------- Tests ----------------
    task automatic test_reset();
        logic [95:0] outs;
        rst = 1'b1;
        tick(); tick();
        outs = {rd_en, rd_addr, mm_enable, mm_a, mm_b, mm_duv, mm_comp, mm_dec,
                wr_en, wr_addr, wr_data, busy, done, err};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs); end
        rst = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({busy, done, rd_en, wr_en} !== 4'b0) begin
            n_fail++; $display("FAIL reset_idle: got %b expected 0000", {busy, done, rd_en, wr_en});
        end
    endtask

    task automatic test_plain();
        int av[4] = '{1, 2, 3, 4};
        int bv[4] = '{5, 6, 7, 8};
        int ev[4] = '{5, 12, 21, 32};
        bit ok;
        for (int k = 0; k < 4; k++) begin
            ram_a[10+k] = 24'(av[k]); ram_b[10+k] = 24'(bv[k]); ram_d[100+k] = '0;
        end
        clear_log();
        pulse_start(3, 10, 100, 2'b00, 2'b00, 2'b00);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL plain_busy: got %b expected 1", busy); end
        wait_done(60, 1, ok);
        tick(); tick();
        n_cmp++;
        if (!ok || done_cnt != 1) begin n_fail++; $display("FAIL plain_done: got %0d dones expected 1", done_cnt); end
        n_cmp++;
        if (done_cyc - first_rd != 9) begin
            n_fail++; $display("FAIL plain_latency: got %0d expected 9", done_cyc - first_rd);
        end
        n_cmp++;
        if (busy_at_done !== 1'b0) begin n_fail++; $display("FAIL plain_busy_at_done: got 1 expected 0"); end
        n_cmp++;
        if (wc_q.size() != 4) begin n_fail++; $display("FAIL plain_wr_count: got %0d expected 4", wc_q.size()); end
        for (int k = 0; k < 4 && k < wc_q.size(); k++) begin
            n_cmp++;
            if (wa_q[k] != 100 + k || wd_q[k] != ev[k] || wc_q[k] != wc_q[0] + k || int'(ram_d[100+k]) != ev[k]) begin
                n_fail++;
                $display("FAIL plain_write[%0d]: got addr %0d data %0d cyc %0d mem %0d expected addr %0d data %0d cyc %0d",
                         k, wa_q[k], wd_q[k], wc_q[k], ram_d[100+k], 100 + k, ev[k], wc_q[0] + k);
            end
        end
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL plain_err: got %b expected 0", err); end
    endtask

    task automatic test_compress();
        bit ok;
        ram_a[20] = 24'd1664; ram_b[20] = 24'd2580335;
        clear_log();
        pulse_start(0, 20, 30, 2'b00, 2'b01, 2'b00);
        wait_done(30, 1, ok);
        tick(); tick();
        n_cmp++;
        if (!ok || wc_q.size() != 1) begin
            n_fail++; $display("FAIL comp_wr_count: got %0d expected 1", wc_q.size());
        end else begin
            n_cmp++;
            if (wd_q[0] != 512 || wa_q[0] != 30) begin
                n_fail++; $display("FAIL comp_data: got addr %0d data %0d expected addr 30 data 512", wa_q[0], wd_q[0]);
            end
            n_cmp++;
            if (wc_q[0] - first_rd != RL + LATC) begin
                n_fail++; $display("FAIL comp_wr_latency: got %0d expected %0d", wc_q[0] - first_rd, RL + LATC);
            end
        end
        n_cmp++;
        if (done_cyc - first_rd != 1 + RL + LATC) begin
            n_fail++; $display("FAIL comp_done_latency: got %0d expected %0d", done_cyc - first_rd, 1 + RL + LATC);
        end
        n_cmp++;
        if (err !== 1'b0 || mm_comp !== 2'b01) begin
            n_fail++; $display("FAIL comp_err_mode: got err %b comp %b expected err 0 comp 01", err, mm_comp);
        end
    endtask

    task automatic test_start_ignored();
        int ev[8];
        bit ok, bad_addr;
        for (int k = 0; k < 8; k++) begin
            ram_a[40+k] = 24'($urandom_range(0, Q-1)); ram_b[40+k] = 24'($urandom_range(0, Q-1));
            ev[k] = ref_mul(int'(ram_a[40+k]), int'(ram_b[40+k]), 1'b0);
        end
        clear_log();
        pulse_start(7, 40, 140, 2'b00, 2'b00, 2'b00);
        tick();
        pulse_start(2, 10, 200, 2'b11, 2'b01, 2'b01);
        n_cmp++;
        if ({mm_duv, mm_comp, mm_dec} !== 6'b0) begin
            n_fail++; $display("FAIL ign_mode: got %b expected 000000", {mm_duv, mm_comp, mm_dec});
        end
        wait_done(60, 1, ok);
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL ign_done: got %0d dones busy %b expected 1 dones busy 0", done_cnt, busy);
        end
        bad_addr = (wc_q.size() != 8);
        for (int k = 0; k < wc_q.size() && k < 8; k++)
            if (wa_q[k] != 140 + k || wd_q[k] != ev[k]) bad_addr = 1'b1;
        n_cmp++;
        if (bad_addr) begin n_fail++; $display("FAIL ign_results: got %0d writes expected 8 plain writes to 140..147", wc_q.size()); end
    endtask

    task automatic test_mid_reset();
        logic [95:0] outs;
        bit ok;
        int ev[4];
        clear_log();
        pulse_start(7, 50, 150, 2'b01, 2'b01, 2'b00);
        for (int i = 0; i < 20 && rd_q.size() < 2; i++) tick();
        rst = 1'b1;
        #1;
        outs = {rd_en, rd_addr, mm_enable, mm_a, mm_b, mm_duv, mm_comp, mm_dec,
                wr_en, wr_addr, wr_data, busy, done, err};
        n_cmp++;
        if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", outs); end
        tick(); tick();
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (wc_q.size() != 0 || done_cnt != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_quiet: got %0d writes %0d dones busy %b expected 0 0 0", wc_q.size(), done_cnt, busy);
        end
        for (int k = 0; k < 4; k++) begin
            ram_a[50+k] = 24'($urandom_range(0, Q-1)); ram_b[50+k] = 24'($urandom_range(0, Q-1));
            ev[k] = ref_mul(int'(ram_a[50+k]), int'(ram_b[50+k]), 1'b0);
        end
        pulse_start(3, 50, 150, 2'b00, 2'b00, 2'b00);
        wait_done(40, 1, ok);
        tick();
        n_cmp++;
        if (!ok || wc_q.size() != 4) begin
            n_fail++; $display("FAIL rst_rerun_count: got %0d writes expected 4", wc_q.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                n_cmp++;
                if (wa_q[k] != 150 + k || wd_q[k] != ev[k]) begin
                    n_fail++; $display("FAIL rst_rerun[%0d]: got %0d/%0d expected %0d/%0d", k, wa_q[k], wd_q[k], 150 + k, ev[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        int sa[3] = '{254, 255, 0};
        int da[3] = '{255, 0, 1};
        int ev[3];
        bit ok;
        for (int k = 0; k < 3; k++) begin
            ram_a[sa[k]] = 24'($urandom_range(0, Q-1)); ram_b[sa[k]] = 24'($urandom_range(0, Q-1));
            ev[k] = ref_mul(int'(ram_a[sa[k]]), int'(ram_b[sa[k]]), 1'b0);
        end
        clear_log();
        pulse_start(2, 254, 255, 2'b00, 2'b00, 2'b00);
        wait_done(40, 1, ok);
        tick();
        n_cmp++;
        if (!ok || rd_q.size() != 3 || wc_q.size() != 3) begin
            n_fail++; $display("FAIL wrap_count: got %0d reads %0d writes expected 3 3", rd_q.size(), wc_q.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (rd_q[k] != sa[k] || wa_q[k] != da[k] || wd_q[k] != ev[k]) begin
                    n_fail++;
                    $display("FAIL wrap[%0d]: got rd %0d wr %0d data %0d expected rd %0d wr %0d data %0d",
                             k, rd_q[k], wa_q[k], wd_q[k], sa[k], da[k], ev[k]);
                end
            end
        end
    endtask

    task automatic test_err();
        int ev[8];
        bit ok, bad;
        for (int k = 0; k < 8; k++) begin
            ram_a[60+k] = 24'($urandom_range(0, Q-1)); ram_b[60+k] = 24'($urandom_range(0, Q-1));
            ev[k] = ref_mul(int'(ram_a[60+k]), int'(ram_b[60+k]), 1'b0);
        end
        clear_log();
        pulse_start(7, 60, 160, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 30 && wc_q.size() < 1; i++) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        wait_done(40, 1, ok);
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
        bad = !ok || (wc_q.size() != 8);
        for (int k = 0; k < wc_q.size() && k < 8; k++)
            if (wa_q[k] != 160 + k || wd_q[k] != ev[k]) bad = 1'b1;
        n_cmp++;
        if (bad) begin n_fail++; $display("FAIL err_data: got %0d writes expected 8 correct writes", wc_q.size()); end
        clear_log();
        pulse_start(0, 60, 170, 2'b00, 2'b00, 2'b00);
        n_cmp++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err); end
        wait_done(30, 1, ok);
        tick();
        n_cmp++;
        if (!ok || err !== 1'b0) begin n_fail++; $display("FAIL err_clean_run: got err %b done %b expected 0 1", err, ok); end
    endtask

    task automatic test_back_to_back();
        int ev[5];
        int ea[5] = '{170, 171, 172, 180, 181};
        bit ok;
        for (int k = 0; k < 3; k++) begin
            ram_a[70+k] = 24'($urandom_range(0, Q-1)); ram_b[70+k] = 24'($urandom_range(0, Q-1));
            ev[k] = ref_mul(int'(ram_a[70+k]), int'(ram_b[70+k]), 1'b0);
        end
        for (int k = 0; k < 2; k++) begin
            ram_a[80+k] = 24'($urandom_range(0, Q-1)); ram_b[80+k] = 24'($urandom_range(0, Q-1));
            ev[3+k] = ref_mul(int'(ram_a[80+k]), int'(ram_b[80+k]), 1'b1);
        end
        clear_log();
        pulse_start(2, 70, 170, 2'b00, 2'b00, 2'b00);
        for (int i = 0; i < 40 && done !== 1'b1; i++) tick();
        pulse_start(1, 80, 180, 2'b00, 2'b01, 2'b00);
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        wait_done(40, 2, ok);
        tick();
        n_cmp++;
        if (!ok || dc_q.size() != 2 || rc_q.size() != 5) begin
            n_fail++; $display("FAIL b2b_runs: got %0d dones %0d reads expected 2 5", dc_q.size(), rc_q.size());
        end else begin
            n_cmp++;
            if (rc_q[3] != dc_q[0] + 1 || dc_q[1] - rc_q[3] != 2 + RL + LATC) begin
                n_fail++; $display("FAIL b2b_timing: got start gap %0d run %0d expected 1 %0d",
                                   rc_q[3] - dc_q[0], dc_q[1] - rc_q[3], 2 + RL + LATC);
            end
        end
        n_cmp++;
        if (wc_q.size() != 5) begin
            n_fail++; $display("FAIL b2b_wr_count: got %0d expected 5", wc_q.size());
        end else begin
            for (int k = 0; k < 5; k++) begin
                n_cmp++;
                if (wa_q[k] != ea[k] || wd_q[k] != ev[k]) begin
                    n_fail++; $display("FAIL b2b_write[%0d]: got %0d/%0d expected %0d/%0d", k, wa_q[k], wd_q[k], ea[k], ev[k]);
                end
            end
        end
    endtask

    task automatic test_random();
        int l, s, d, lat, bad;
        bit cp, ok;
        int ev[16];
        for (int r = 0; r < 6; r++) begin
            l  = $urandom_range(0, 15);
            s  = $urandom_range(0, 63);
            d  = 128 + $urandom_range(0, 63);
            cp = 1'($urandom_range(0, 1));
            lat = cp ? LATC : LATP;
            for (int k = 0; k <= l; k++) begin
                ram_a[s+k] = 24'($urandom_range(0, Q-1)); ram_b[s+k] = 24'($urandom_range(0, Q-1));
                ev[k] = ref_mul(int'(ram_a[s+k]), int'(ram_b[s+k]), cp);
            end
            clear_log();
            pulse_start(l, s, d, 2'b00, cp ? 2'b01 : 2'b00, 2'b00);
            wait_done(80, 1, ok);
            tick();
            n_cmp++;
            if (!ok || wc_q.size() != l + 1 || done_cyc - first_rd != l + 1 + RL + lat) begin
                n_fail++;
                $display("FAIL rand%0d_shape: got %0d writes latency %0d expected %0d writes latency %0d",
                         r, wc_q.size(), done_cyc - first_rd, l + 1, l + 1 + RL + lat);
            end else begin
                bad = 0;
                for (int k = 0; k <= l; k++)
                    if (wa_q[k] != d + k || wd_q[k] != ev[k] || wc_q[k] != first_rd + RL + lat + k) bad++;
                n_cmp++;
                if (bad != 0) begin n_fail++; $display("FAIL rand%0d_data: got %0d bad writes expected 0", r, bad); end
            end
            n_cmp++;
            if (err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_err: got %b expected 0", r, err); end
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) begin ram_a[k] = '0; ram_b[k] = '0; ram_d[k] = '0; end
        test_reset();
        test_plain();
        test_compress();
        test_start_ignored();
        test_mid_reset();
        test_wrap();
        test_err();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
